// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESP_HIT,
    FILL_REQ,
    FILL_WAIT,
    WRITE
  } state_t;

  localparam int unsigned LINE_WORDS  = 8;
  localparam int unsigned OFFSET_BITS = 5;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid bits and tags for each cache line; combinational hit lookup, one write port.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned INDEX_BITS = $clog2(NUM_LINES),
  parameter int unsigned TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] lookup_index,
  input  logic [TAG_BITS-1:0]   lookup_tag,
  output logic                  hit,
  input  logic                  set_valid,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [TAG_BITS-1:0]   write_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tags [NUM_LINES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid <= '0;
    else if (set_valid) valid[write_index] <= 1'b1;
  end

  // Tags need no reset: a cleared valid bit masks whatever the tag holds.
  always_ff @(posedge clk) begin
    if (set_valid) tags[write_index] <= write_tag;
  end

  assign hit = valid[lookup_index] && (tags[lookup_index] == lookup_tag);

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES           = 16,
  parameter int unsigned VALID_ADDRESS_WIDTH = 18
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cpu_req_valid,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_address,
  input  logic [31:0]  cpu_write_data,
  input  logic [3:0]   cpu_write_mask,
  output logic         cpu_ready,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_read_data,
  output logic         mem_write_enable,
  output logic [31:0]  mem_address,
  output logic [31:0]  mem_write_data,
  output logic [3:0]   mem_write_mask,
  input  logic [255:0] mem_read_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS;

  if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0 || VALID_ADDRESS_WIDTH > 32) begin : g_param_check
    $error("dcache_controller: NUM_LINES must be a power of two >= 2, VALID_ADDRESS_WIDTH <= 32");
  end

  state_t state, state_next;

  logic        req_write;
  logic        req_hit;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic [3:0]  req_mask;

  logic                  lookup_hit;
  logic                  accept;
  logic                  fill_en;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [2:0]            req_offset;
  line_t                 fill_line;
  line_t                 lines [NUM_LINES];

  assign req_offset = req_address[4:2];
  assign req_index  = req_address[OFFSET_BITS +: INDEX_BITS];
  assign req_tag    = req_address[31 -: TAG_BITS];
  assign fill_line  = mem_read_data;
  assign accept     = cpu_req_valid && cpu_ready;

  dcache_tag_array #(
    .NUM_LINES (NUM_LINES)
  ) u_tags (
    .clk          (clk),
    .reset_n      (reset_n),
    .lookup_index (cpu_address[OFFSET_BITS +: INDEX_BITS]),
    .lookup_tag   (cpu_address[31 -: TAG_BITS]),
    .hit          (lookup_hit),
    .set_valid    (fill_en),
    .write_index  (req_index),
    .write_tag    (req_tag)
  );

  // Hit status is captured at accept; valid bits cannot change before the store completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_write   <= 1'b0;
      req_hit     <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
      req_mask    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_write   <= cpu_write;
        req_hit     <= lookup_hit;
        req_address <= cpu_address;
        req_data    <= cpu_write_data;
        req_mask    <= cpu_write_mask;
      end
    end
  end

  always_comb begin
    state_next       = state;
    cpu_ready        = 1'b0;
    cpu_resp_valid   = 1'b0;
    cpu_read_data    = '0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_mask   = '0;
    fill_en          = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) begin
          if (cpu_write)       state_next = WRITE;
          else if (lookup_hit) state_next = RESP_HIT;
          else                 state_next = FILL_REQ;
        end
      end
      RESP_HIT: begin
        cpu_resp_valid = 1'b1;
        cpu_read_data  = lines[req_index][req_offset];
        state_next     = IDLE;
      end
      FILL_REQ: begin
        mem_address = {req_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        state_next  = FILL_WAIT;
      end
      FILL_WAIT: begin
        cpu_resp_valid = 1'b1;
        cpu_read_data  = fill_line[req_offset];
        fill_en        = 1'b1;
        state_next     = IDLE;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_address      = req_address;
        mem_write_data   = req_data;
        mem_write_mask   = req_mask;
        cpu_resp_valid   = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      lines[req_index] <= fill_line;
    end else if (state == WRITE && req_write && req_hit) begin
      lines[req_index][req_offset] <= merge_bytes(lines[req_index][req_offset], req_data, req_mask);
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (lookup_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
